// File: rtl/fsm_step_sequencer.sv
// fsm_step_sequencer
//
// Drives the four-phase demo FSM (IDLE 000 -> COUNT 001 -> WAIT 010 -> DONE 011).
// It issues single-cycle advance pulses, dwells in WAIT and DONE for a programmable
// number of prescaled ticks, and watches the FSM state for timeouts and mismatches.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   start_i      level input, a rising edge is a request
//   abort_i      level input, forces FAULT
//   auto_i       1: WAIT exits on dwell, 0: WAIT exits on a start edge
//   fsm_state_i  FSM state feedback
//   adv_o        registered advance pulse to the FSM
//   exp_state_o  expected FSM state (111 in FAULT)
//   busy_o       high in COUNT, WAIT or DONE
//   done_o       one-cycle pulse on sequence completion
//   fault_o      high while in FAULT
module fsm_step_sequencer #(
    parameter logic [23:0] TICK_DIV    = 24'd10_000_000,
    parameter logic [7:0]  COUNT_TICKS = 8'd4,
    parameter logic [7:0]  WAIT_TICKS  = 8'd5,
    parameter logic [7:0]  DONE_TICKS  = 8'd3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       auto_i,
    input  logic [2:0] fsm_state_i,
    output logic       adv_o,
    output logic [2:0] exp_state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fault_o
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCount = 3'd1,
        StWait  = 3'd2,
        StDone  = 3'd3,
        StFault = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] presc_q;
    logic [7:0]  ticks_q;
    logic        start_q;
    logic        entry_q;   // first cycle of the current state
    logic        adv_q, adv_d;
    logic        done_q, done_d;
    logic [2:0]  exp_q, exp_d;
    logic        busy_q, fault_q;

    logic start_edge, tick, mismatch, timeout, state_change;

    assign start_edge   = start_i & ~start_q;
    assign tick         = (presc_q == TICK_DIV - 24'd1);
    // FSM only reflects an adv one cycle later, so skip the entry cycle.
    assign mismatch     = ~entry_q && (state_q == StWait || state_q == StDone) &&
                          (fsm_state_i != exp_q);
    assign timeout      = (state_q == StCount) && tick && (ticks_q == COUNT_TICKS - 8'd1);
    assign state_change = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        adv_d   = 1'b0;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = StFault;
        end else if (mismatch || timeout) begin
            state_d = StFault;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_d = StCount;
                        adv_d   = 1'b1;
                    end
                end
                StCount: begin
                    if (fsm_state_i == 3'b010) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (auto_i ? (tick && ticks_q == WAIT_TICKS - 8'd1) : start_edge) begin
                        state_d = StDone;
                        adv_d   = 1'b1;
                    end
                end
                StDone: begin
                    if (tick && ticks_q == DONE_TICKS - 8'd1) begin
                        state_d = StIdle;
                        adv_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end
                StFault: begin
                    // Recovery returns to IDLE silently; the FSM is not advanced.
                    if (start_edge) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        exp_d = 3'b000;
        unique case (state_d)
            StIdle:  exp_d = 3'b000;
            StCount: exp_d = 3'b001;
            StWait:  exp_d = 3'b010;
            StDone:  exp_d = 3'b011;
            StFault: exp_d = 3'b111;
            default: exp_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            presc_q <= '0;
            ticks_q <= '0;
            start_q <= 1'b1;   // a start held through reset is not a request
            entry_q <= 1'b1;
            adv_q   <= 1'b0;
            done_q  <= 1'b0;
            exp_q   <= 3'b000;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            entry_q <= state_change;
            adv_q   <= adv_d;
            done_q  <= done_d;
            exp_q   <= exp_d;
            busy_q  <= (state_d == StCount) || (state_d == StWait) || (state_d == StDone);
            fault_q <= (state_d == StFault);
            if (state_change) begin
                presc_q <= '0;
                ticks_q <= '0;
            end else begin
                presc_q <= tick ? 24'd0 : presc_q + 24'd1;
                if (tick) begin
                    ticks_q <= ticks_q + 8'd1;
                end
            end
        end
    end

    assign adv_o       = adv_q;
    assign done_o      = done_q;
    assign exp_state_o = exp_q;
    assign busy_o      = busy_q;
    assign fault_o     = fault_q;

endmodule
